// File: rtl/spi_host_master.sv
// spi_host_master
//   SPI mode 0 (CPOL=0, CPHA=0) host that shifts one 8-bit frame per
//   accepted start request. Data moves MSB first in both directions.
//   Slave select can stay low across frames (keep_ss), so back-to-back
//   frames can form one longer transaction.
//
// Parameters
//   HALF_PERIOD : clk cycles per SCK half-period (1..255)
//
// Ports
//   clk      in   system clock, rising edge
//   n_rst    in   asynchronous active-low reset
//   start    in   frame request; accepted only when no frame is active
//   tx_data  in   [7:0] frame to send, captured on acceptance
//   keep_ss  in   captured on acceptance; 1 keeps SS low after the frame
//   MISO     in   serial data from the slave
//   SCK      out  serial clock, idles low
//   SS       out  active-low slave select
//   MOSI     out  serial data to the slave
//   busy     out  high while a frame is in progress
//   done     out  one-cycle pulse when a frame completes
//   rx_data  out  [7:0] last received frame
module spi_host_master #(
  parameter int unsigned HALF_PERIOD = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       keep_ss,
  input  logic       MISO,
  output logic       SCK,
  output logic       SS,
  output logic       MOSI,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data
);

  localparam logic [7:0] HP = 8'(HALF_PERIOD);

  typedef enum logic [2:0] {
    IDLE,
    SELECTED,
    LEAD,
    SHIFT,
    DONE
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] hp_cnt_q, hp_cnt_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic       keep_q, keep_d;
  logic       sck_q, sck_d;
  logic       ss_q, ss_d;
  logic       mosi_q, mosi_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] rx_data_q, rx_data_d;

  // State and every output live in flops; reset abandons any frame at once.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      hp_cnt_q  <= 8'd0;
      bit_cnt_q <= 4'd0;
      tx_sh_q   <= 8'd0;
      rx_sh_q   <= 8'd0;
      keep_q    <= 1'b0;
      sck_q     <= 1'b0;
      ss_q      <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rx_data_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      hp_cnt_q  <= hp_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      keep_q    <= keep_d;
      sck_q     <= sck_d;
      ss_q      <= ss_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rx_data_q <= rx_data_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    hp_cnt_d  = hp_cnt_q;
    bit_cnt_d = bit_cnt_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    keep_d    = keep_q;
    sck_d     = sck_q;
    ss_d      = ss_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rx_data_d = rx_data_q;

    case (state_q)
      // DONE is the single cycle in which the done pulse is visible. busy
      // is already low there, so it accepts a new request just like the
      // resting states; that lets a frame follow directly on the next one.
      IDLE, SELECTED, DONE: begin
        if (state_q == DONE) begin
          state_d = keep_q ? SELECTED : IDLE;
        end
        if (start) begin
          state_d   = LEAD;
          tx_sh_d   = tx_data;
          keep_d    = keep_ss;
          hp_cnt_d  = 8'd0;
          bit_cnt_d = 4'd0;
        end
      end

      // Entered on the accepting edge. The first LEAD edge asserts SS and
      // presents the MSB; the first SCK rise follows HALF_PERIOD edges later.
      // HP is at least 1, so the two comparisons never hit together.
      LEAD: begin
        hp_cnt_d = hp_cnt_q + 8'd1;
        if (hp_cnt_q == 8'd0) begin
          ss_d   = 1'b0;
          mosi_d = tx_sh_q[7];
          busy_d = 1'b1;
        end
        if (hp_cnt_q == HP) begin
          sck_d    = 1'b1;
          rx_sh_d  = {rx_sh_q[6:0], MISO};
          hp_cnt_d = 8'd1;
          state_d  = SHIFT;
        end
      end

      // hp_cnt runs 1..HP between toggles, so it never wraps. Rises sample
      // MISO; falls advance MOSI, except the 8th fall, which ends the frame.
      SHIFT: begin
        if (hp_cnt_q == HP) begin
          hp_cnt_d = 8'd1;
          if (!sck_q) begin
            sck_d   = 1'b1;
            rx_sh_d = {rx_sh_q[6:0], MISO};
          end else begin
            sck_d     = 1'b0;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              done_d    = 1'b1;
              busy_d    = 1'b0;
              rx_data_d = rx_sh_q;
              ss_d      = ~keep_q;
              state_d   = DONE;
            end else begin
              mosi_d  = tx_sh_q[6];
              tx_sh_d = {tx_sh_q[6:0], 1'b0};
            end
          end
        end else begin
          hp_cnt_d = hp_cnt_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign SCK     = sck_q;
  assign SS      = ss_q;
  assign MOSI    = mosi_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_host_master.sv
// tb_spi_host_master
//   Scoreboard bench for spi_host_master. Each frame request pushes its
//   expected receive byte, transmitted bit pattern and completion cycle.
//   A monitor pops one entry per done pulse and compares.
//   A second instance with HALF_PERIOD=1 covers the fastest SCK rate.
module tb_spi_host_master;

  typedef struct {
    logic [7:0] rx;
    logic [7:0] mosi;
    int         done_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       keep_ss = 1'b0;
  logic       miso;
  logic       sck, ss, mosi, busy, done;
  logic [7:0] rx_data;

  logic       start1 = 1'b0;
  logic       sck1, ss1, mosi1, busy1, done1;
  logic [7:0] rx_data1;

  logic       loopback = 1'b1;
  logic [7:0] slave_sh = 8'h00;
  logic [7:0] mosi_cap = 8'h00;
  int         sck_rises = 0;
  int         ss_rises = 0;
  int         cyc = 0;
  int         tests = 0;
  int         failures = 0;
  exp_t       sb[$];

  spi_host_master #(.HALF_PERIOD(2)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .tx_data(tx_data),
    .keep_ss(keep_ss), .MISO(miso), .SCK(sck), .SS(ss), .MOSI(mosi),
    .busy(busy), .done(done), .rx_data(rx_data)
  );

  spi_host_master #(.HALF_PERIOD(1)) dut1 (
    .clk(clk), .n_rst(n_rst), .start(start1), .tx_data(8'h81),
    .keep_ss(1'b0), .MISO(mosi1), .SCK(sck1), .SS(ss1), .MOSI(mosi1),
    .busy(busy1), .done(done1), .rx_data(rx_data1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Slave model: either echoes MOSI or shifts out a preloaded byte,
  // changing its bit on each SCK fall as mode 0 requires.
  assign miso = loopback ? mosi : slave_sh[7];

  always @(negedge sck) slave_sh = {slave_sh[6:0], 1'b0};

  always @(posedge sck) begin
    mosi_cap = {mosi_cap[6:0], mosi};
    sck_rises++;
  end

  always @(posedge ss) ss_rises++;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding frame.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done) begin
      checkOutput("done_expected", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("rx_data", rx_data, e.rx);
        checkOutput("mosi_bits", mosi_cap, e.mosi);
        checkOutput("done_cycle", cyc, e.done_cyc);
        checkOutput("sck_rises", sck_rises, 8);
        checkOutput("busy_at_done", busy, 0);
      end
      sck_rises = 0;
    end
  end

  // Drives one request, records the expectation, and checks the first
  // edge after acceptance.
  task automatic applyStimulus(input logic [7:0] tx, input logic keep,
                               input logic lb, input logic [7:0] slave_word);
    exp_t e;
    int   n;
    @(negedge clk);
    loopback = lb;
    slave_sh = slave_word;
    tx_data  = tx;
    keep_ss  = keep;
    start    = 1'b1;
    @(posedge clk);
    #1;
    n     = cyc;
    start = 1'b0;
    e.rx       = lb ? tx : slave_word;
    e.mosi     = tx;
    e.done_cyc = n + 1 + 16 * 2;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput("ss_low_n1", ss, 0);
    checkOutput("busy_n1", busy, 1);
    checkOutput("mosi_msb_n1", mosi, tx[7]);
    checkOutput("sck_low_n1", sck, 0);
  endtask

  task automatic waitFrames(input int budget);
    int c = 0;
    while (sb.size() != 0 && c < budget) begin
      @(posedge clk);
      #2;
      c++;
    end
    checkOutput("frame_timeout", sb.size(), 0);
  endtask

  initial begin
    int ss_base;
    int c;
    int n;
    int done_at;
    int done_count;
    logic [15:0] sck_obs;

    // Reset values while held in reset, with clocks running.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_sck", sck, 0);
    checkOutput("rst_ss", ss, 1);
    checkOutput("rst_mosi", mosi, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_rx", rx_data, 8'h00);
    #1;
    n_rst = 1'b1;

    // Loopback A5, accepted on the first edge after release.
    applyStimulus(8'hA5, 1'b0, 1'b1, 8'h00);
    waitFrames(100);
    checkOutput("ss_high_after_a5", ss, 1);

    // Slave returns 3C while the host sends zeros.
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h3C);
    waitFrames(100);

    // Two chained frames with SS held low between them.
    ss_base = ss_rises;
    applyStimulus(8'h12, 1'b1, 1'b1, 8'h00);
    waitFrames(100);
    checkOutput("ss_held_low", ss, 0);
    applyStimulus(8'h34, 1'b0, 1'b1, 8'h00);
    waitFrames(100);
    checkOutput("ss_rises_chain", ss_rises - ss_base, 1);
    checkOutput("ss_high_after_34", ss, 1);

    // A start mid-frame must be ignored.
    applyStimulus(8'h0F, 1'b0, 1'b1, 8'h00);
    repeat (10) @(negedge clk);
    tx_data = 8'hFF;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    waitFrames(100);
    repeat (40) @(posedge clk);
    checkOutput("idle_after_ignore", busy, 0);

    // Reset after the 4th SCK rise abandons the frame.
    sck_rises = 0;
    applyStimulus(8'h5A, 1'b0, 1'b1, 8'h00);
    c = 0;
    while (sck_rises < 4 && c < 100) begin
      @(posedge clk);
      #2;
      c++;
    end
    checkOutput("rise4_reached", sck_rises, 4);
    n_rst = 1'b0;
    #1;
    checkOutput("arst_ss", ss, 1);
    checkOutput("arst_sck", sck, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_rx", rx_data, 8'h00);
    sb.delete();
    @(posedge clk);
    #1;
    checkOutput("arst_done", done, 0);
    n_rst = 1'b1;
    sck_rises = 0;
    applyStimulus(8'hC3, 1'b0, 1'b1, 8'h00);
    waitFrames(100);

    // HALF_PERIOD=1 instance: SCK at clk/2, done at N+17.
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    start1 = 1'b0;
    done_at = -1;
    done_count = 0;
    sck_obs = 16'h0000;
    @(posedge clk);
    #1;
    checkOutput("hp1_ss_low", ss1, 0);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      sck_obs[16 - k] = sck1;
      if (done1) begin
        done_at = cyc;
        done_count++;
      end
    end
    @(posedge clk);
    #1;
    if (done1) done_count++;
    checkOutput("hp1_sck_pattern", sck_obs, 16'hAAAA);
    checkOutput("hp1_done_cycle", done_at, n + 17);
    checkOutput("hp1_done_count", done_count, 1);
    checkOutput("hp1_rx", rx_data1, 8'h81);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
